// File: rtl/wb_ram64_pkg.sv
// Shared types and constants for the Wishbone-to-64-bit RAM bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_ram64_pkg;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    RD_WAIT
  } state_t;

  localparam int ROW_W         = 10;
  localparam int BYTES_PER_ROW = 8;
  localparam int HALF_BIT      = 2;

  // Steer a 32-bit byte-select onto the addressed half of a 64-bit row.
  function automatic logic [BYTES_PER_ROW-1:0] half_we(input logic half, input logic [3:0] sel);
    return half ? {sel, 4'b0000} : {4'b0000, sel};
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Row counter that walks every RAM row once after reset.
// Latency: one row per enabled cycle; done is combinational on the last row.
// Backpressure: none; advances whenever en is high.
module ram_clear_seq #(
  parameter int ROWS = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  output logic [$clog2(ROWS)-1:0] clr_cnt,
  output logic                     done
);

  localparam int RW = $clog2(ROWS);

  // Last row is being written this cycle.
  assign done = en && (clr_cnt == RW'(ROWS - 1));

  // Row counter restarts at zero on every reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt <= '0;
    end else if (en) begin
      clr_cnt <= clr_cnt + RW'(1);
    end
  end

endmodule

// File: rtl/wb_ram64_bridge.sv
// Wishbone classic 32-bit slave over a 1024x64 byte-enabled sync-read RAM, with one-row read buffer.
// Latency: write/buffer-hit ack 1 cycle after request; read miss ack 2 cycles after request.
// Backpressure: requests are held without ack while the post-reset clear runs; one-cycle ack pulse.
module wb_ram64_bridge
  import wb_ram64_pkg::*;
#(
  parameter int CLEAR_ON_RESET = 1,
  parameter int ROWS           = 2 ** ROW_W,
  parameter int ADDR_W         = $clog2(ROWS) + 3
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_we_i,
  input  logic [3:0]               wb_sel_i,
  input  logic [ADDR_W-1:0]        wb_adr_i,
  input  logic [31:0]              wb_dat_i,
  output logic [31:0]              wb_dat_o,
  output logic                     wb_ack_o,
  output logic                     init_done,
  output logic                     ram_en,
  output logic [BYTES_PER_ROW-1:0] ram_we,
  output logic [$clog2(ROWS)-1:0]  ram_a,
  output logic [63:0]              ram_di,
  input  logic [63:0]              ram_do
);

  localparam int RW = $clog2(ROWS);

  state_t          state, state_nxt;
  logic [RW-1:0]   row, pend_row, buf_row, clr_cnt;
  logic            half, pend_half, buf_valid;
  logic [63:0]     buf_dat;
  logic            req, hit, clr_en, clr_done;
  logic            unused_adr;

  // Bytes within a 32-bit word are addressed by wb_sel_i, so the low address bits carry nothing.
  assign unused_adr = ^wb_adr_i[1:0];

  assign row    = wb_adr_i[ADDR_W-1:3];
  assign half   = wb_adr_i[HALF_BIT];
  assign req    = wb_cyc_i && wb_stb_i && !wb_ack_o;
  assign hit    = buf_valid && (buf_row == row);
  assign clr_en = (state == INIT) && !RST;

  ram_clear_seq #(.ROWS(ROWS)) u_clear (
    .clk     (CLK),
    .rst     (RST),
    .en      (clr_en),
    .clr_cnt (clr_cnt),
    .done    (clr_done)
  );

  // State register; reset chooses between clearing first and serving immediately.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= (CLEAR_ON_RESET != 0) ? INIT : IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and the RAM port mux between the clear walker and the bus path.
  always_comb begin
    state_nxt = state;
    ram_en    = 1'b0;
    ram_we    = '0;
    ram_a     = clr_cnt;
    ram_di    = '0;
    case (state)
      INIT: begin
        ram_en = 1'b1;
        ram_we = {BYTES_PER_ROW{1'b1}};
        if (clr_done) state_nxt = IDLE;
      end
      IDLE: begin
        if (req) begin
          if (wb_we_i) begin
            ram_en = 1'b1;
            ram_a  = row;
            ram_di = {wb_dat_i, wb_dat_i};
            ram_we = half_we(half, wb_sel_i);
          end else if (!hit) begin
            ram_en    = 1'b1;
            ram_a     = row;
            state_nxt = RD_WAIT;
          end
        end
      end
      RD_WAIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // The macro must see no access while reset is held.
    if (RST) begin
      ram_en = 1'b0;
      ram_we = '0;
    end
  end

  // Bus response, row buffer fill/invalidate and init flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
      init_done <= 1'b0;
      buf_valid <= 1'b0;
      buf_row   <= '0;
      buf_dat   <= '0;
      pend_row  <= '0;
      pend_half <= 1'b0;
    end else begin
      wb_ack_o  <= 1'b0;
      init_done <= (state_nxt != INIT);
      case (state)
        IDLE: begin
          if (req) begin
            if (wb_we_i) begin
              wb_ack_o <= 1'b1;
              if (hit) buf_valid <= 1'b0;
            end else if (hit) begin
              wb_ack_o <= 1'b1;
              wb_dat_o <= half ? buf_dat[63:32] : buf_dat[31:0];
            end else begin
              pend_row  <= row;
              pend_half <= half;
            end
          end
        end
        RD_WAIT: begin
          // The buffer fills even if the master abandoned the cycle.
          buf_dat   <= ram_do;
          buf_row   <= pend_row;
          buf_valid <= 1'b1;
          if (wb_cyc_i) begin
            wb_ack_o <= 1'b1;
            wb_dat_o <= pend_half ? ram_do[63:32] : ram_do[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ram64_bridge.sv
module tb_wb_ram64_bridge;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [3:0]  wb_sel_i = 4'h0;
  logic [12:0] wb_adr_i = 13'h0;
  logic [31:0] wb_dat_i = 32'h0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, init_done, ram_en;
  logic [7:0]  ram_we;
  logic [9:0]  ram_a;
  logic [63:0] ram_di, ram_do;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        chk;
    logic [31:0] dat;
  } exp_t;
  exp_t exp_q[$];

  logic        preload = 1'b1;
  logic [63:0] mem [1024];

  logic        cap_en;
  logic [9:0]  cap_a;
  logic [7:0]  cap_we;
  logic [63:0] cap_di;

  always #5 CLK = ~CLK;

  wb_ram64_bridge dut (
    .CLK       (CLK),
    .RST       (RST),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_we_i   (wb_we_i),
    .wb_sel_i  (wb_sel_i),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_dat_o  (wb_dat_o),
    .wb_ack_o  (wb_ack_o),
    .init_done (init_done),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_a     (ram_a),
    .ram_di    (ram_di),
    .ram_do    (ram_do)
  );

  // Behavioural 1024x64 byte-enabled sync-read RAM, preloaded with a nonzero pattern.
  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 64'hA5A5_A5A5_A5A5_A5A5;
    end else if (ram_en) begin
      for (int b = 0; b < 8; b++)
        if (ram_we[b]) mem[ram_a][b*8 +: 8] <= ram_di[b*8 +: 8];
      ram_do <= mem[ram_a];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every ack pops one expectation; reads also compare data.
  always @(negedge CLK) begin
    if (wb_ack_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack with dat %h expected no ack", wb_dat_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.chk) chk("read_data", {32'h0, wb_dat_o}, {32'h0, e.dat});
      end
    end
  end

  task automatic wb_xfer(input logic we, input logic [12:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, input int exp_lat, input logic [31:0] exp_dat,
                         input string nm);
    int   n;
    exp_t e;
    @(posedge CLK); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = dat;
    e.chk = !we;
    e.dat = exp_dat;
    exp_q.push_back(e);
    @(negedge CLK);
    cap_en = ram_en; cap_a = ram_a; cap_we = ram_we; cap_di = ram_di;
    n = 0;
    while (wb_ack_o !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk({nm, "_lat"}, 64'(n), 64'(exp_lat));
    @(posedge CLK); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  // Called at the start of clear cycle 0 (first cycle after reset released).
  task automatic do_clear(input bit with_req);
    exp_t e;
    for (int c = 0; c < 1024; c++) begin
      if (c > 0) begin @(posedge CLK); #1; end
      if (with_req && c == 10) begin
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = 13'h0000; wb_sel_i = 4'hF;
        e.chk = 1'b1;
        e.dat = 32'h0;
        exp_q.push_back(e);
      end
      @(negedge CLK);
      chk("clear_row", {42'h0, ram_en, ram_we, ram_a, init_done, wb_ack_o, |ram_di},
                       {42'h0, 1'b1, 8'hFF, 10'(c), 1'b0, 1'b0, 1'b0});
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("init_done_1024", 64'(init_done), 64'h1);
    if (with_req) begin
      chk("held_req_miss", {45'h0, ram_en, ram_we, ram_a}, {45'h0, 1'b1, 8'h00, 10'h000});
      chk("held_req_ack_c1024", 64'(wb_ack_o), 64'h0);
      @(negedge CLK);
      chk("held_req_ack_c1025", 64'(wb_ack_o), 64'h0);
      @(negedge CLK);
      chk("held_req_ack_c1026", 64'(wb_ack_o), 64'h1);
      @(posedge CLK); #1;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    end else begin
      chk("idle_ram_en", 64'(ram_en), 64'h0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    @(posedge CLK); #1;
    preload = 1'b0;
    @(negedge CLK);
    chk("reset_outputs", {30'h0, wb_ack_o, wb_dat_o, init_done, ram_en},
                         {30'h0, 1'b0, 32'h0, 1'b0, 1'b0});
    chk("reset_ram_we", 64'(ram_we), 64'h0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // 1: full clear with a request held from cycle 10
    do_clear(1'b1);

    // 2: write high half of row 0, readback misses (buffer invalidated), then low-half hit
    wb_xfer(1'b1, 13'h0004, 4'hF, 32'hDEADBEEF, 1, 32'h0, "wr_0004");
    chk("wr_0004_ram", {45'h0, cap_en, cap_we, cap_a}, {45'h0, 1'b1, 8'hF0, 10'd0});
    chk("wr_0004_di", cap_di, 64'hDEADBEEF_DEADBEEF);
    wb_xfer(1'b0, 13'h0004, 4'hF, 32'h0, 2, 32'hDEADBEEF, "rd_0004");
    wb_xfer(1'b0, 13'h0000, 4'hF, 32'h0, 1, 32'h0, "rd_0000_hit");
    chk("rd_0000_hit_en", 64'(cap_en), 64'h0);

    // 3: single byte into the last row
    wb_xfer(1'b1, 13'h1FF8, 4'b0010, 32'h0000_AB00, 1, 32'h0, "wr_1ff8");
    chk("wr_1ff8_ram", {45'h0, cap_en, cap_we, cap_a}, {45'h0, 1'b1, 8'h02, 10'd1023});
    wb_xfer(1'b0, 13'h1FF8, 4'hF, 32'h0, 2, 32'h0000_AB00, "rd_1ff8");

    // 4: miss on row 2 low half, then hit on its high half
    wb_xfer(1'b1, 13'h0014, 4'hF, 32'hCAFEF00D, 1, 32'h0, "wr_0014");
    wb_xfer(1'b1, 13'h0010, 4'hF, 32'h11223344, 1, 32'h0, "wr_0010");
    wb_xfer(1'b0, 13'h0010, 4'hF, 32'h0, 2, 32'h11223344, "rd_0010_miss");
    chk("rd_0010_miss_en", 64'(cap_en), 64'h1);
    wb_xfer(1'b0, 13'h0014, 4'hF, 32'h0, 1, 32'hCAFEF00D, "rd_0014_hit");
    chk("rd_0014_hit_en", 64'(cap_en), 64'h0);

    // 5: write into the buffered row forces the next read to miss
    wb_xfer(1'b0, 13'h0020, 4'hF, 32'h0, 2, 32'h0, "rd_0020");
    wb_xfer(1'b1, 13'h0024, 4'hF, 32'h12345678, 1, 32'h0, "wr_0024");
    wb_xfer(1'b0, 13'h0024, 4'hF, 32'h0, 2, 32'h12345678, "rd_0024");
    chk("rd_0024_en", 64'(cap_en), 64'h1);

    // 6a: cycle abandoned in RD_WAIT -> no ack, buffer still fills, dat_o holds
    @(posedge CLK); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 13'h0030;
    @(negedge CLK);
    chk("abandon_miss_en", 64'(ram_en), 64'h1);
    @(posedge CLK); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("abandon_no_ack", 64'(wb_ack_o), 64'h0);
    end
    chk("dat_o_hold", 64'(wb_dat_o), 64'h12345678);
    wb_xfer(1'b0, 13'h0034, 4'hF, 32'h0, 1, 32'h0, "rd_0034_hit");
    chk("rd_0034_hit_en", 64'(cap_en), 64'h0);

    // 6b: reset in the middle of a clear restarts it from row 0
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int i = 0; i < 500; i++) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_mid_clear", {53'h0, ram_en, ram_a}, {53'h0, 1'b0, 10'd500});
    @(posedge CLK); #1;
    RST = 1'b0;
    do_clear(1'b0);
    wb_xfer(1'b0, 13'h1FF8, 4'hF, 32'h0, 2, 32'h0, "rd_1ff8_cleared");
    chk("rd_1ff8_cleared_en", 64'(cap_en), 64'h1);
    wb_xfer(1'b0, 13'h0014, 4'hF, 32'h0, 2, 32'h0, "rd_0014_cleared");

    repeat (3) @(negedge CLK);
    chk("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
